// File: rtl/mem_pkg.sv
// Shared definitions for the data memory controller.
// Size encodings, FSM states and latency limit.
package mem_pkg;

  localparam int LATENCY_MAX = 15;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data memory controller.
// Store mask/shift, load extract/extend and alignment fault.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] word_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        fault_o
);

  logic [4:0]  sh_amt;
  logic [31:0] rsh;

  assign sh_amt  = {off_i, 3'b000};
  assign rsh     = word_i >> sh_amt;
  assign wdata_o = wdata_i << sh_amt;

  always_comb begin
    mask_o  = 4'b0000;
    rdata_o = 32'h0;
    fault_o = 1'b0;
    case (size_i)
      SZ_BYTE: begin
        mask_o  = 4'b0001 << off_i;
        rdata_o = unsigned_i ? {24'h0, rsh[7:0]}
                             : {{24{rsh[7]}}, rsh[7:0]};
      end
      SZ_HALF: begin
        mask_o  = 4'b0011 << off_i;
        rdata_o = unsigned_i ? {16'h0, rsh[15:0]}
                             : {{16{rsh[15]}}, rsh[15:0]};
        fault_o = off_i[0];
      end
      SZ_WORD: begin
        mask_o  = 4'b1111;
        rdata_o = rsh;
        fault_o = |off_i;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Single-port data memory with valid/ready request/response,
// configurable access latency and sized, aligned accesses.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 0,
  localparam int AW     = $clog2(DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          mem_we;

  logic [31:0] mem_q [DEPTH];

  logic          idle;
  logic [1:0]    al_size;
  logic [1:0]    al_off;
  logic          al_uns;
  logic [31:0]   al_wdata;
  logic [3:0]    al_mask;
  logic [31:0]   al_wsh;
  logic [31:0]   al_rdata;
  logic          al_fault;
  logic [AW-3:0] idx;

  // In IDLE the aligner judges the incoming request; afterwards it
  // works on the captured one.
  assign idle     = (state_q == ST_IDLE);
  assign al_size  = idle ? req_size : size_q;
  assign al_off   = idle ? req_addr[1:0] : addr_q[1:0];
  assign al_uns   = idle ? req_unsigned : uns_q;
  assign al_wdata = idle ? req_wdata : wdata_q;
  assign idx      = addr_q[AW-1:2];

  mem_lane_align u_align (
    .size_i     (al_size),
    .off_i      (al_off),
    .unsigned_i (al_uns),
    .wdata_i    (al_wdata),
    .word_i     (mem_q[idx]),
    .mask_o     (al_mask),
    .wdata_o    (al_wsh),
    .rdata_o    (al_rdata),
    .fault_o    (al_fault)
  );

  assign req_ready = idle;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (al_fault) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(LATENCY);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          mem_we  = we_q;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'h0 : al_rdata;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (al_mask[i]) mem_q[idx][8*i +: 8] <= al_wsh[8*i +: 8];
      end
    end
  end

endmodule
